// File: rtl/output_datapath.sv
// Transmit side of the systolic MAC: snapshots the 4x4 result matrix on mac_done
// and streams it row by row over a 64-bit valid/ready link.
module output_datapath #(
  parameter int ACC_W = 16,
  parameter int N     = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mac_done,
  input  logic [N*N*ACC_W-1:0]   c_in,
  input  logic                   dest_ready,
  output logic                   source_valid,
  output logic [N*ACC_W-1:0]     data_out,
  output logic [1:0]             row_idx,
  output logic                   acc_clear,
  output logic                   tx_done,
  output logic                   busy,
  output logic                   capture_drop
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [1:0] LAST_ROW = 2'(N - 1);

  state_t                 state, state_nxt;
  logic [N*N*ACC_W-1:0]   buffer, buffer_nxt;
  logic [1:0]             row_nxt;
  logic                   valid_nxt;
  logic [N*ACC_W-1:0]     data_nxt;
  logic                   acc_clear_nxt;
  logic                   tx_done_nxt;
  logic                   drop_nxt;
  logic                   fire;
  logic                   last_fire;

  // Column 0 of the row lands in the most significant lane of the beat.
  function automatic logic [N*ACC_W-1:0] row_beat(
    input logic [N*N*ACC_W-1:0] mat,
    input logic [1:0]           r
  );
    logic [N*ACC_W-1:0] beat;
    beat = '0;
    for (int unsigned c = 0; c < N; c++) begin
      beat[(N-1-c)*ACC_W +: ACC_W] = mat[(int'(r)*N + c)*ACC_W +: ACC_W];
    end
    return beat;
  endfunction

  assign fire      = source_valid & dest_ready;
  assign last_fire = fire & (row_idx == LAST_ROW);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    buffer_nxt    = buffer;
    row_nxt       = row_idx;
    valid_nxt     = source_valid;
    acc_clear_nxt = 1'b0;
    tx_done_nxt   = 1'b0;
    drop_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (mac_done) begin
          buffer_nxt    = c_in;
          row_nxt       = '0;
          acc_clear_nxt = 1'b1;
          valid_nxt     = 1'b1;
          state_nxt     = SEND;
        end
      end
      SEND: begin
        valid_nxt = 1'b1;
        if (last_fire) begin
          tx_done_nxt = 1'b1;
          row_nxt     = '0;
          if (mac_done) begin
            // Back-to-back: the next matrix follows with no bubble on the link.
            buffer_nxt    = c_in;
            acc_clear_nxt = 1'b1;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end else begin
          if (fire) begin
            row_nxt = row_idx + 2'd1;
          end
          if (mac_done) begin
            drop_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        row_nxt   = '0;
      end
    endcase

    // Beat is registered from the next-state view so it stays stable until fire.
    data_nxt = valid_nxt ? row_beat(buffer_nxt, row_nxt) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      buffer       <= '0;
      row_idx      <= '0;
      source_valid <= 1'b0;
      data_out     <= '0;
      acc_clear    <= 1'b0;
      tx_done      <= 1'b0;
      capture_drop <= 1'b0;
    end else begin
      state        <= state_nxt;
      buffer       <= buffer_nxt;
      row_idx      <= row_nxt;
      source_valid <= valid_nxt;
      data_out     <= data_nxt;
      acc_clear    <= acc_clear_nxt;
      tx_done      <= tx_done_nxt;
      capture_drop <= drop_nxt;
    end
  end

endmodule
